// File: rtl/mask_centroid_tracker.sv
// mask_centroid_tracker
//   Accumulates the object mask of one video frame (pixel count, coordinate
//   sums, bounding box), snapshots it at the last active pixel, and divides the
//   sums by the count to produce the centroid. Results are published with a
//   one-cycle o_valid pulse. If a frame ends while the previous result is still
//   being computed, that frame is dropped and o_overrun pulses.
//
// Ports
//   clk                     rising-edge clock
//   reset                   synchronous reset, active low
//   i_mask[11]              mask pixel (1 = object); other bits ignored
//   x_coor, y_coor          pixel column / row, aligned with i_mask
//   DE                      pixel qualifier
//   o_valid                 one-cycle pulse when the outputs below update
//   o_found                 reported frame reached MIN_PIXELS
//   o_count                 mask pixel count of the reported frame
//   o_cx, o_cy              centroid (floor of mean column / row)
//   o_xmin..o_ymax          bounding box
//   o_overrun               one-cycle pulse when a frame result is dropped
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | idle; frame-end pixel snapshots accumulators and starts divide
// DIV   | 28 restoring-division iterations, one per clock
// DONE  | load output registers; o_valid follows on the next cycle

module mask_centroid_tracker #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int MIN_PIXELS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] i_mask,
    input  logic [9:0]  x_coor,
    input  logic [9:0]  y_coor,
    input  logic        DE,
    output logic        o_valid,
    output logic        o_found,
    output logic [18:0] o_count,
    output logic [9:0]  o_cx,
    output logic [9:0]  o_cy,
    output logic [9:0]  o_xmin,
    output logic [9:0]  o_xmax,
    output logic [9:0]  o_ymin,
    output logic [9:0]  o_ymax,
    output logic        o_overrun
);

    localparam logic [10:0] W_LIM   = 11'(IMG_WIDTH);
    localparam logic [10:0] H_LIM   = 11'(IMG_HEIGHT);
    localparam logic [9:0]  X_LAST  = 10'(IMG_WIDTH - 1);
    localparam logic [9:0]  Y_LAST  = 10'(IMG_HEIGHT - 1);
    localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);

    typedef enum logic [1:0] {ST_ACCUM, ST_DIV, ST_DONE} state_t;

    state_t state_q, state_d;

    // live accumulators
    logic [18:0] cnt_q;
    logic [27:0] sx_q, sy_q;
    logic [9:0]  xmin_q, xmax_q, ymin_q, ymax_q;

    // snapshot and divider
    logic [18:0] snap_cnt_q;
    logic [9:0]  snap_xmin_q, snap_xmax_q, snap_ymin_q, snap_ymax_q;
    logic [27:0] dvd_x_q, dvd_y_q;
    logic [18:0] rem_x_q, rem_y_q;
    logic [4:0]  iter_q;
    logic        run_q;

    // output registers
    logic        valid_q, found_q, overrun_q;
    logic [18:0] count_q;
    logic [9:0]  cx_q, cy_q, oxmin_q, oxmax_q, oymin_q, oymax_q;

    logic pix_acc, pix_hit, frame_end;
    logic snap_load, div_step, out_load, drop;

    logic [18:0] cnt_upd;
    logic [27:0] sx_upd, sy_upd;
    logic [9:0]  xmin_upd, xmax_upd, ymin_upd, ymax_upd;

    assign pix_acc   = DE && ({1'b0, x_coor} < W_LIM) && ({1'b0, y_coor} < H_LIM);
    assign pix_hit   = pix_acc && i_mask[11];
    assign frame_end = pix_acc && (x_coor == X_LAST) && (y_coor == Y_LAST);

    // accumulator values including the current pixel; the snapshot uses these
    // so the frame-end pixel itself is counted
    assign cnt_upd  = pix_hit ? cnt_q + 19'd1 : cnt_q;
    assign sx_upd   = pix_hit ? sx_q + 28'(x_coor) : sx_q;
    assign sy_upd   = pix_hit ? sy_q + 28'(y_coor) : sy_q;
    assign xmin_upd = (pix_hit && x_coor < xmin_q) ? x_coor : xmin_q;
    assign xmax_upd = (pix_hit && x_coor > xmax_q) ? x_coor : xmax_q;
    assign ymin_upd = (pix_hit && y_coor < ymin_q) ? y_coor : ymin_q;
    assign ymax_upd = (pix_hit && y_coor > ymax_q) ? y_coor : ymax_q;

    // one restoring-division iteration: returns {remainder, shifted dividend/quotient}
    function automatic logic [46:0] div_iter(input logic [18:0] rem,
                                             input logic [27:0] dvd,
                                             input logic [18:0] den);
        logic [19:0] rsh;
        logic        ge;
        rsh = {rem, dvd[27]};
        ge  = (rsh >= {1'b0, den});
        if (ge) rsh = rsh - {1'b0, den};
        return {rsh[18:0], dvd[26:0], ge};
    endfunction

    logic [46:0] step_x, step_y;
    assign step_x = div_iter(rem_x_q, dvd_x_q, snap_cnt_q);
    assign step_y = div_iter(rem_y_q, dvd_y_q, snap_cnt_q);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_ACCUM;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (frame_end) state_d = ST_DIV;
            ST_DIV:   if (iter_q == 5'd0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

    // FSM: control outputs
    always_comb begin
        snap_load = (state_q == ST_ACCUM) && frame_end;
        div_step  = (state_q == ST_DIV);
        out_load  = (state_q == ST_DONE);
        drop      = (state_q != ST_ACCUM) && frame_end;
    end

    // live accumulators; every frame end restarts them, whether or not the
    // frame is kept
    always_ff @(posedge clk) begin
        if (!reset || frame_end) begin
            cnt_q  <= '0;
            sx_q   <= '0;
            sy_q   <= '0;
            xmin_q <= 10'h3FF;
            xmax_q <= '0;
            ymin_q <= 10'h3FF;
            ymax_q <= '0;
        end else begin
            cnt_q  <= cnt_upd;
            sx_q   <= sx_upd;
            sy_q   <= sy_upd;
            xmin_q <= xmin_upd;
            xmax_q <= xmax_upd;
            ymin_q <= ymin_upd;
            ymax_q <= ymax_upd;
        end
    end

    // snapshot and dividers; below MIN_PIXELS the dividers stay idle but the
    // sequence still runs so the report timing does not depend on the count
    always_ff @(posedge clk) begin
        if (!reset) begin
            snap_cnt_q  <= '0;
            snap_xmin_q <= '0;
            snap_xmax_q <= '0;
            snap_ymin_q <= '0;
            snap_ymax_q <= '0;
            dvd_x_q     <= '0;
            dvd_y_q     <= '0;
            rem_x_q     <= '0;
            rem_y_q     <= '0;
            iter_q      <= '0;
            run_q       <= 1'b0;
        end else if (snap_load) begin
            snap_cnt_q  <= cnt_upd;
            snap_xmin_q <= xmin_upd;
            snap_xmax_q <= xmax_upd;
            snap_ymin_q <= ymin_upd;
            snap_ymax_q <= ymax_upd;
            dvd_x_q     <= sx_upd;
            dvd_y_q     <= sy_upd;
            rem_x_q     <= '0;
            rem_y_q     <= '0;
            iter_q      <= 5'd27;
            run_q       <= (cnt_upd >= MIN_CNT);
        end else if (div_step) begin
            iter_q <= iter_q - 5'd1;
            if (run_q) begin
                {rem_x_q, dvd_x_q} <= step_x;
                {rem_y_q, dvd_y_q} <= step_y;
            end
        end
    end

    // output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            found_q   <= 1'b0;
            count_q   <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            oxmin_q   <= '0;
            oxmax_q   <= '0;
            oymin_q   <= '0;
            oymax_q   <= '0;
        end else begin
            valid_q   <= out_load;
            overrun_q <= drop;
            if (out_load) begin
                found_q <= run_q;
                count_q <= snap_cnt_q;
                cx_q    <= run_q ? dvd_x_q[9:0] : 10'd0;
                cy_q    <= run_q ? dvd_y_q[9:0] : 10'd0;
                oxmin_q <= run_q ? snap_xmin_q : 10'd0;
                oxmax_q <= run_q ? snap_xmax_q : 10'd0;
                oymin_q <= run_q ? snap_ymin_q : 10'd0;
                oymax_q <= run_q ? snap_ymax_q : 10'd0;
            end
        end
    end

    assign o_valid   = valid_q;
    assign o_overrun = overrun_q;
    assign o_found   = found_q;
    assign o_count   = count_q;
    assign o_cx      = cx_q;
    assign o_cy      = cy_q;
    assign o_xmin    = oxmin_q;
    assign o_xmax    = oxmax_q;
    assign o_ymin    = oymin_q;
    assign o_ymax    = oymax_q;

    // quotient upper bits are always zero (mean of 10-bit values)
    logic unused_bits;
    assign unused_bits = ^{i_mask[10:0], dvd_x_q[27:10], dvd_y_q[27:10]};

endmodule

// File: tb/tb_mask_centroid_tracker.sv
module tb_mask_centroid_tracker;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int MINP = 2;
    localparam int LAT  = 29;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] i_mask = '0;
    logic [9:0]  x_coor = '0;
    logic [9:0]  y_coor = '0;
    logic        DE = 1'b0;
    logic        o_valid, o_found, o_overrun;
    logic [18:0] o_count;
    logic [9:0]  o_cx, o_cy, o_xmin, o_xmax, o_ymin, o_ymax;

    always #5 clk = ~clk;

    mask_centroid_tracker #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_PIXELS(MINP)) dut (
        .clk(clk), .reset(reset), .i_mask(i_mask), .x_coor(x_coor), .y_coor(y_coor),
        .DE(DE), .o_valid(o_valid), .o_found(o_found), .o_count(o_count),
        .o_cx(o_cx), .o_cy(o_cy), .o_xmin(o_xmin), .o_xmax(o_xmax),
        .o_ymin(o_ymin), .o_ymax(o_ymax), .o_overrun(o_overrun)
    );

    typedef struct packed {
        logic        found;
        logic [18:0] count;
        logic [9:0]  cx, cy, xmin, xmax, ymin, ymax;
    } res_t;

    res_t exp_q[$], obs_q[$];
    int   exp_t[$], obs_t[$];
    int   total = 0, bad = 0;
    int   ecnt = 0;
    int   exp_ovr = 0, obs_ovr = 0;
    int   px[$], py[$];
    bit   pend = 0;
    int   pend_t = 0;
    res_t pend_r = '0;
    int   last_fe = -1000;
    res_t last_rep = '0;
    bit   fm [W][H];

    function automatic res_t cur_out();
        return {o_found, o_count, o_cx, o_cy, o_xmin, o_xmax, o_ymin, o_ymax};
    endfunction

    // reference: statistics of the collected object pixels of one frame
    function automatic res_t frame_result();
        res_t r;
        int n, sx, sy, x0, x1, y0, y1;
        r = '0;
        n = px.size();
        r.count = 19'(n);
        if (n >= MINP) begin
            sx = 0; sy = 0; x0 = 1023; y0 = 1023; x1 = 0; y1 = 0;
            foreach (px[i]) begin
                sx += px[i];
                sy += py[i];
                if (px[i] < x0) x0 = px[i];
                if (px[i] > x1) x1 = px[i];
                if (py[i] < y0) y0 = py[i];
                if (py[i] > y1) y1 = py[i];
            end
            r.found = 1'b1;
            r.cx = 10'(sx / n);
            r.cy = 10'(sy / n);
            r.xmin = 10'(x0); r.xmax = 10'(x1);
            r.ymin = 10'(y0); r.ymax = 10'(y1);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            obs_q.push_back(cur_out());
            obs_t.push_back(ecnt);
        end
        if (o_overrun === 1'b1) obs_ovr++;
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // one clock edge of stimulus; the model tracks the result pipeline by edge index
    task automatic step(input bit m, input int x, input int y, input bit de);
        i_mask = {m, 11'($urandom)};
        x_coor = 10'(x);
        y_coor = 10'(y);
        DE     = de;
        @(posedge clk);
        #1;
        ecnt++;
        if (pend && ecnt == pend_t) begin
            exp_q.push_back(pend_r);
            exp_t.push_back(pend_t);
            last_rep = pend_r;
            pend = 0;
        end
        if (de && x < W && y < H) begin
            if (m) begin
                px.push_back(x);
                py.push_back(y);
            end
            if (x == W - 1 && y == H - 1) begin
                if (ecnt - last_fe > LAT) begin
                    pend   = 1;
                    pend_r = frame_result();
                    pend_t = ecnt + LAT;
                    last_fe = ecnt;
                end else begin
                    exp_ovr++;
                end
                px.delete();
                py.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'($urandom), W - 1, H - 1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        DE    = 1'b0;
        @(posedge clk);
        #1;
        ecnt++;
        pend = 0;
        px.delete();
        py.delete();
        last_fe  = -1000;
        last_rep = '0;
        reset = 1'b1;
    endtask

    // gap: 0 = none, 1 = DE low every other cycle, 2 = random gaps and out-of-range pixels
    task automatic frame(input int gap);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (gap == 1) step(1'($urandom), x, y, 1'b0);
                if (gap == 2 && $urandom_range(0, 2) == 0) step(1'b1, x, y, 1'b0);
                if (gap == 2 && $urandom_range(0, 4) == 0) step(1'b1, W + $urandom_range(0, 1), y, 1'b1);
                if (gap == 2 && $urandom_range(0, 6) == 0) step(1'b1, x, H + $urandom_range(0, 1), 1'b1);
                step(fm[x][y], x, y, 1'b1);
            end
        end
    endtask

    task automatic fill(input int density);
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                fm[x][y] = ($urandom_range(0, 99) < density);
    endtask

    task automatic block();
        fill(0);
        fm[3][2] = 1; fm[4][2] = 1; fm[3][3] = 1; fm[4][3] = 1;
    endtask

    task automatic check_all(input string tag);
        int n;
        chk({tag, "_nres"}, 80'(obs_q.size()), 80'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_res"}, obs_q[i], exp_q[i]);
            chk({tag, "_edge"}, 80'(obs_t[i]), 80'(exp_t[i]));
        end
        chk({tag, "_ovr"}, 80'(obs_ovr), 80'(exp_ovr));
        chk({tag, "_hold"}, cur_out(), last_rep);
        chk({tag, "_vld_low"}, 80'(o_valid), 80'(0));
        obs_q.delete(); obs_t.delete(); exp_q.delete(); exp_t.delete();
        obs_ovr = 0; exp_ovr = 0;
    endtask

    initial begin
        do_reset();
        chk("reset_out", cur_out(), 80'(0));
        chk("reset_flags", 80'({o_valid, o_overrun}), 80'(0));

        // 2x2 block
        block();
        frame(0);
        idle(40);
        chk("blk_const", cur_out(), {1'b1, 19'd4, 10'd3, 10'd2, 10'd3, 10'd4, 10'd2, 10'd3});
        check_all("blk");

        // single pixel, below minimum
        fill(0); fm[5][1] = 1;
        frame(0);
        idle(40);
        chk("single_const", cur_out(), {1'b0, 19'd1, 60'd0});
        check_all("single");

        // exactly MIN_PIXELS pixels
        fill(0); fm[0][0] = 1; fm[7][5] = 1;
        frame(0);
        idle(40);
        chk("minp_const", cur_out(), {1'b1, 19'd2, 10'd3, 10'd2, 10'd0, 10'd7, 10'd0, 10'd5});
        check_all("minp");

        // all-zero frame with DE gapped
        fill(0);
        frame(1);
        idle(40);
        check_all("zero_gap");

        // repeated frame-end pixel -> overrun, first result unchanged
        block(); fm[7][5] = 1;
        frame(0);
        step(1'b1, W - 1, H - 1, 1'b1);
        idle(40);
        chk("ovr_const", cur_out(), {1'b1, 19'd5, 10'd4, 10'd3, 10'd3, 10'd7, 10'd2, 10'd5});
        check_all("ovr");

        // reset 10 edges after frame end aborts the computation
        block();
        frame(0);
        idle(9);
        do_reset();
        chk("abort_out", cur_out(), 80'(0));
        idle(40);
        check_all("abort");
        fill(30);
        frame(0);
        idle(40);
        check_all("after_abort");

        // back-to-back full then empty frame
        fill(100);
        frame(0);
        fill(0);
        frame(0);
        idle(40);
        check_all("b2b");

        // randomized frames, gaps, out-of-range pixels and early frame ends
        for (int f = 0; f < 8; f++) begin
            fill($urandom_range(0, 60));
            frame(2);
            if ($urandom_range(0, 2) == 0) begin
                for (int k = $urandom_range(0, 20); k > 0; k--)
                    step(1'($urandom), $urandom_range(0, W - 1), $urandom_range(0, H - 1), 1'($urandom));
                step(1'($urandom), W - 1, H - 1, 1'b1);
            end
            idle($urandom_range(0, 35));
            idle(40);
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
